mdio_master_ctrl: RTL and testbench

- System-clock command sequencer that sits directly upstream of the MDIO serial engine (mdio_com).
- Generates MDC from clk and accepts register read/write commands over a valid/ready handshake.
- Drives the engine's start/if_read/mdio_data inputs, waits for its transfer-end flag, and returns read data or a timeout error.
- Used by PHY bring-up and status logic.

---
 rtl/mdio_pkg.sv | 24 ++
 rtl/mdc_gen.sv | 37 +++
 rtl/mdio_master_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_mdio_master_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// Shared types and constants for the MDIO master command sequencer.
// Holds the FSM state encoding, bus widths, PHY status register details and a counter-width helper.
package mdio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } mdio_state_e;

  localparam int REG_W   = 5;
  localparam int DATA_W  = 16;
  localparam int FRAME_W = 24;

  localparam logic [REG_W-1:0] PHY_STATUS_REG = 5'd1;
  localparam int               LINK_BIT       = 2;

  // Bits needed for a counter that has to reach max_count inclusive.
  function automatic int cnt_width(input int max_count);
    return (max_count < 2) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/mdc_gen.sv
// MDC divider: toggles mdc every HALF_PERIOD clk cycles.
// mdc_rise is high for exactly the clk cycle in which mdc has just gone 0->1.
module mdc_gen
  import mdio_pkg::*;
#(
  parameter int HALF_PERIOD = 1250
) (
  input  logic clk,
  input  logic rst,
  output logic mdc,
  output logic mdc_rise
);

  localparam int CW = cnt_width(HALF_PERIOD - 1);

  logic [CW-1:0] div_cnt;
  logic          wrap;

  assign wrap = (div_cnt == CW'(HALF_PERIOD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      mdc      <= 1'b0;
      mdc_rise <= 1'b0;
    end else begin
      mdc_rise <= wrap && !mdc;
      if (wrap) begin
        div_cnt <= '0;
        mdc     <= ~mdc;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mdio_master_ctrl.sv
// Command sequencer in front of the mdio_com serial engine: generates MDC, arms/starts transfers and returns responses.
// Build option MDIO_POLL_EN adds a periodic internal read of the PHY status register that maintains link_up.
module mdio_master_ctrl
  import mdio_pkg::*;
#(
  parameter int MDC_HALF_PERIOD = 1250,
  parameter int ARM_MDC_EDGES   = 2,
  parameter int TIMEOUT_MDC     = 64
`ifdef MDIO_POLL_EN
  ,
  parameter int POLL_MDC        = 20000
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_rd,
  input  logic [REG_W-1:0]   cmd_reg,
  input  logic [DATA_W-1:0]  cmd_wdata,
  output logic               rsp_valid,
  output logic [DATA_W-1:0]  rsp_rdata,
  output logic               rsp_err,
  output logic               busy,
  output logic               mdc,
  output logic               com_start,
  output logic               com_if_read,
  output logic [FRAME_W-1:0] com_mdio_data,
  input  logic               com_tr_end,
  input  logic [DATA_W-1:0]  com_phy_reg,
  output logic               com_reset_n,
  output logic               link_up
);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] ARM  = ST_ARM;
  localparam logic [1:0] RUN  = ST_RUN;
  localparam logic [1:0] DONE = ST_DONE;

  localparam int EDGE_MAX = (ARM_MDC_EDGES > TIMEOUT_MDC) ? ARM_MDC_EDGES : TIMEOUT_MDC;
  localparam int EW       = cnt_width(EDGE_MAX);

  logic [1:0]        state;
  logic              ready_en;
  logic              rd_l;
  logic [REG_W-1:0]  reg_l;
  logic [DATA_W-1:0] wdata_l;
  logic [EW-1:0]     edge_cnt;
  logic [EW-1:0]     edge_next;
  logic [1:0]        tr_sync;
  logic              tr_end_s;
  logic              mdc_rise;
  logic              accept;
  logic              arm_done;
  logic              timeout_hit;
  logic              run_end;
  logic              poll_start;
  logic              poll_active;

  mdc_gen #(
    .HALF_PERIOD (MDC_HALF_PERIOD)
  ) u_mdc_gen (
    .clk      (clk),
    .rst      (rst),
    .mdc      (mdc),
    .mdc_rise (mdc_rise)
  );

  assign com_reset_n   = ~rst;
  assign busy          = (state != IDLE);
  assign cmd_ready     = (state == IDLE) && ready_en;
  assign com_start     = (state == RUN);
  assign com_if_read   = rd_l;
  assign com_mdio_data = {3'b000, reg_l, wdata_l};
  assign rsp_valid     = (state == DONE) && !poll_active;

  assign accept      = cmd_valid && cmd_ready;
  assign edge_next   = edge_cnt + 1'b1;
  assign arm_done    = mdc_rise && (edge_next == EW'(ARM_MDC_EDGES));
  assign timeout_hit = mdc_rise && (edge_next == EW'(TIMEOUT_MDC));
  assign run_end     = (state == RUN) && (tr_end_s || timeout_hit);
  assign tr_end_s    = tr_sync[1];

  // com_tr_end is produced in the MDC domain by the engine.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tr_sync <= 2'b00;
    end else begin
      tr_sync <= {tr_sync[0], com_tr_end};
    end
  end

  // Response fields are only touched by external commands so a poll never disturbs them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ready_en  <= 1'b0;
      rd_l      <= 1'b0;
      reg_l     <= '0;
      wdata_l   <= '0;
      edge_cnt  <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            rd_l     <= cmd_rd;
            reg_l    <= cmd_reg;
            wdata_l  <= cmd_wdata;
            edge_cnt <= '0;
            state    <= ARM;
          end else if (poll_start) begin
            rd_l     <= 1'b1;
            reg_l    <= PHY_STATUS_REG;
            wdata_l  <= '0;
            edge_cnt <= '0;
            state    <= ARM;
          end
        end
        ARM: begin
          if (arm_done) begin
            edge_cnt <= '0;
            state    <= RUN;
          end else if (mdc_rise) begin
            edge_cnt <= edge_next;
          end
        end
        RUN: begin
          if (tr_end_s) begin
            state <= DONE;
            if (!poll_active) begin
              rsp_err   <= 1'b0;
              rsp_rdata <= rd_l ? com_phy_reg : '0;
            end
          end else if (timeout_hit) begin
            state <= DONE;
            if (!poll_active) begin
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end
          end else if (mdc_rise) begin
            edge_cnt <= edge_next;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef MDIO_POLL_EN
  localparam int PW = cnt_width(POLL_MDC);

  logic [PW-1:0] poll_cnt;
  logic          poll_due;

  assign poll_due   = (poll_cnt == PW'(POLL_MDC));
  assign poll_start = (state == IDLE) && ready_en && poll_due && !cmd_valid;

  // The timer only advances while idle, and saturates until a poll can be launched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      poll_cnt    <= '0;
      poll_active <= 1'b0;
      link_up     <= 1'b0;
    end else begin
      if (poll_start) begin
        poll_cnt <= '0;
      end else if ((state == IDLE) && mdc_rise && !poll_due) begin
        poll_cnt <= poll_cnt + 1'b1;
      end

      if (poll_start) begin
        poll_active <= 1'b1;
      end else if (state == DONE) begin
        poll_active <= 1'b0;
      end

      if (run_end && poll_active) begin
        link_up <= tr_end_s && com_phy_reg[LINK_BIT];
      end
    end
  end
`else
  assign poll_start  = 1'b0;
  assign poll_active = 1'b0;
  assign link_up     = 1'b0;
`endif

endmodule

// File: tb/tb_mdio_master_ctrl.sv
// Self-checking bench for mdio_master_ctrl with a behavioural mdio_com engine model.
// Define MDIO_POLL_EN to also exercise the link-status poll.
module tb_mdio_master_ctrl;

  localparam int HALF    = 3;
  localparam int ARM_E   = 2;
  localparam int TMO     = 64;
  localparam int MAX_LAT = ARM_E + 35;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_rd = 1'b0;
  logic [4:0]  cmd_reg = '0;
  logic [15:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        mdc;
  logic        com_start;
  logic        com_if_read;
  logic [23:0] com_mdio_data;
  logic        com_tr_end;
  logic [15:0] com_phy_reg;
  logic        com_reset_n;
  logic        link_up;

  int checks = 0;
  int errors = 0;

  // Engine model controls
  logic [15:0] eng_data = 16'h0000;
  bit          eng_hang = 1'b0;
  int          eng_lat  = 10;
  int          eng_cnt  = 0;

  mdio_master_ctrl #(
    .MDC_HALF_PERIOD (HALF),
    .ARM_MDC_EDGES   (ARM_E),
    .TIMEOUT_MDC     (TMO)
`ifdef MDIO_POLL_EN
    ,
    .POLL_MDC        (4)
`endif
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_rd        (cmd_rd),
    .cmd_reg       (cmd_reg),
    .cmd_wdata     (cmd_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .busy          (busy),
    .mdc           (mdc),
    .com_start     (com_start),
    .com_if_read   (com_if_read),
    .com_mdio_data (com_mdio_data),
    .com_tr_end    (com_tr_end),
    .com_phy_reg   (com_phy_reg),
    .com_reset_n   (com_reset_n),
    .link_up       (link_up)
  );

  always #5 clk = ~clk;

  // Engine: start low clears it; with start high it counts MDC rises and raises tr_end after eng_lat of them.
  always @(posedge mdc or posedge rst) begin
    if (rst) begin
      eng_cnt    <= 0;
      com_tr_end <= 1'b0;
    end else if (!com_start) begin
      eng_cnt    <= 0;
      com_tr_end <= 1'b0;
    end else if (!eng_hang) begin
      if (eng_cnt >= eng_lat) com_tr_end <= 1'b1;
      else eng_cnt <= eng_cnt + 1;
    end
  end

  assign com_phy_reg = com_tr_end ? eng_data : 16'hDEAD;

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Issue one command and follow it to its response, measuring MDC rises in each phase.
  task automatic applyStimulus(input logic rd, input logic [4:0] rg, input logic [15:0] wd,
                               input logic [15:0] phy, input bit hang, input bit hold_valid,
                               input bit expect_next_clk);
    int          guard;
    int          arm_rises, run_rises, total_rises;
    bit          seen, start_seen, frame_bad;
    logic        prev_mdc;
    logic [23:0] exp_frame;
    logic [15:0] exp_rdata;
    logic        exp_err;

    exp_frame = {3'b000, rg, wd};
    exp_err   = hang;
    exp_rdata = (rd && !hang) ? phy : 16'h0000;
    eng_data  = phy;
    eng_hang  = hang;
    eng_lat   = int'($urandom_range(10, 30));

    cmd_valid = 1'b1;
    cmd_rd    = rd;
    cmd_reg   = rg;
    cmd_wdata = wd;

    guard = 0;
    while (!cmd_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("accept_wait", 32'(guard < 2000), 32'd1);
    if (expect_next_clk) checkOutput("b2b_accept_clk", 32'(guard), 32'd1);

    prev_mdc = mdc;
    @(negedge clk);
    checkOutput("busy_after_accept", 32'(busy), 32'd1);
    checkOutput("start_low_in_arm", 32'(com_start), 32'd0);
    checkOutput("if_read", 32'(com_if_read), 32'(rd));
    checkOutput("mdio_frame", 32'(com_mdio_data), 32'(exp_frame));

    if (!hold_valid) begin
      cmd_valid = 1'b0;
      cmd_rd    = 1'($urandom);
      cmd_reg   = 5'($urandom);
      cmd_wdata = 16'($urandom);
    end

    arm_rises = 0; run_rises = 0; total_rises = 0;
    seen = 0; start_seen = 0; frame_bad = 0; guard = 0;
    while (!seen && guard < 5000) begin
      if (mdc && !prev_mdc) begin
        total_rises++;
        if (com_start) run_rises++;
        else if (!start_seen) arm_rises++;
      end
      prev_mdc = mdc;
      if (com_start) start_seen = 1;
      if (com_mdio_data !== exp_frame || com_if_read !== rd) frame_bad = 1;
      if (rsp_valid) seen = 1;
      else begin
        @(negedge clk);
        guard++;
      end
    end

    checkOutput("rsp_seen", 32'(seen), 32'd1);
    checkOutput("arm_rises", 32'(arm_rises), 32'(ARM_E));
    checkOutput("frame_stable", 32'(frame_bad), 32'd0);
    checkOutput("rsp_err", 32'(rsp_err), 32'(exp_err));
    checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
    checkOutput("start_low_at_rsp", 32'(com_start), 32'd0);
    if (hang) checkOutput("timeout_rises", 32'(run_rises), 32'(TMO));
    else checkOutput("latency_bound", 32'(total_rises <= MAX_LAT), 32'd1);
  endtask

  initial begin
    int guard;
    bit bad;

    $display("[TB] reset checks");
    repeat (3) @(negedge clk);
    checkOutput("rst_mdc", 32'(mdc), 32'd0);
    checkOutput("rst_start", 32'(com_start), 32'd0);
    checkOutput("rst_if_read", 32'(com_if_read), 32'd0);
    checkOutput("rst_frame", 32'(com_mdio_data), 32'd0);
    checkOutput("rst_ready", 32'(cmd_ready), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rdata", 32'(rsp_rdata), 32'd0);
    checkOutput("rst_err", 32'(rsp_err), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_link", 32'(link_up), 32'd0);
    checkOutput("rst_engine_reset_n", 32'(com_reset_n), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("ready_before_clk", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    checkOutput("ready_after_release", 32'(cmd_ready), 32'd1);

    $display("[TB] directed write / read / timeout");
    applyStimulus(1'b0, 5'd0, 16'h1140, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 5'd2, 16'h0000, 16'h004D, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 5'd3, 16'h0000, 16'h1234, 1'b1, 1'b0, 1'b0);

    $display("[TB] back-to-back writes");
    applyStimulus(1'b0, 5'd4, 16'h01E1, 16'h0000, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'd9, 16'h0300, 16'h0000, 1'b0, 1'b0, 1'b1);

    $display("[TB] reset during RUN");
    eng_hang  = 1'b1;
    cmd_valid = 1'b1;
    cmd_rd    = 1'b1;
    cmd_reg   = 5'd5;
    guard = 0;
    while (!com_start && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("reached_run", 32'(com_start), 32'd1);
    cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_mdc", 32'(mdc), 32'd0);
    checkOutput("midrst_start", 32'(com_start), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) bad = 1;
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) bad = 1;
    end
    checkOutput("midrst_no_rsp", 32'(bad), 32'd0);
    applyStimulus(1'b1, 5'd5, 16'h0000, 16'hA5C3, 1'b0, 1'b0, 1'b0);

    $display("[TB] randomized commands");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'($urandom), 5'($urandom), 16'($urandom), 16'($urandom),
                    ($urandom_range(0, 7) == 0), 1'b0, 1'b0);
    end

`ifdef MDIO_POLL_EN
    $display("[TB] link-status poll");
    for (int p = 0; p < 2; p++) begin
      guard = 0;
      while (busy && guard < 2000) begin
        @(negedge clk);
        guard++;
      end
      eng_hang = 1'b0;
      eng_lat  = 12;
      eng_data = (p == 0) ? 16'h796D : 16'h7969;
      guard = 0;
      while (!busy && guard < 2000) begin
        @(negedge clk);
        guard++;
      end
      checkOutput("poll_started", 32'(busy), 32'd1);
      bad = 0;
      guard = 0;
      while (busy && guard < 2000) begin
        if (rsp_valid || cmd_ready) bad = 1;
        @(negedge clk);
        guard++;
      end
      checkOutput("poll_quiet", 32'(bad), 32'd0);
      checkOutput("poll_link_up", 32'(link_up), 32'(eng_data[2]));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
